// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - state encoding, LCD strings and hex helper shared by the calculator front end
package calc_pkg;

  localparam int TEXT_W = 256;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_RELEASE = 6'b000010,
    ST_ARM     = 6'b000100,
    ST_RUN     = 6'b001000,
    ST_HOLD    = 6'b010000,
    ST_FAULT   = 6'b100000
  } state_e;

  localparam logic [87:0]  MENU_PREFIX  = "Select Op: ";
  localparam logic [31:0]  PAD4         = "    ";
  localparam logic [127:0] INVALID_LINE = "Invalid Op      ";
  localparam logic [127:0] PRESS_LINE   = "Press Btnc      ";
  localparam logic [255:0] FAULT_TEXT   = "Op Timeout      Press Btnc      ";
  localparam logic [255:0] BLANK_TEXT   = {32{8'h20}};

  function automatic logic [7:0] bin2ascii(input logic [3:0] v);
    return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
  endfunction

endpackage

// File: rtl/calc_op_watchdog.sv
// rtl/calc_op_watchdog.sv - RUN-phase cycle counter, instantiated only with CALC_TIMEOUT_EN
module calc_op_watchdog #(
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic Clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q equals the index of the current RUN cycle, so the last allowed cycle flags expiry
  assign expired = run && (count_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/calc_op_sequencer.sv
// rtl/calc_op_sequencer.sv - menu/launch/run controller for the operation units
// CALC_TIMEOUT_EN adds a RUN watchdog that forces FAULT; otherwise fault is tied low.
module calc_op_sequencer #(
  parameter int N_OPS       = 4,
  parameter int TEXT_W      = calc_pkg::TEXT_W,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic [3:0]              sel,
  input  logic                    btn_next,
  input  logic                    btn_back,
  input  logic [N_OPS-1:0]        op_done,
  input  logic [N_OPS*TEXT_W-1:0] op_text,
  output logic [N_OPS-1:0]        op_reset,
  output logic [N_OPS-1:0]        op_enable,
  output logic [N_OPS-1:0]        op_next,
  output logic [TEXT_W-1:0]       textOut,
  output logic                    busy,
  output logic [3:0]              active_op,
  output logic                    fault
);

  import calc_pkg::*;

  localparam logic [4:0] N_OPS_L = 5'(N_OPS);

  state_e              state_q, state_d;
  logic [3:0]          active_op_q, active_op_d;
  logic [N_OPS-1:0]    op_reset_q, op_reset_d;
  logic [N_OPS-1:0]    op_enable_q, op_enable_d;
  logic [N_OPS-1:0]    op_next_q, op_next_d;
  logic [TEXT_W-1:0]   text_q, text_d;
  logic                busy_q, busy_d;

  logic                sel_valid;
  logic                expired;
  logic                done_act;
  logic [N_OPS-1:0]    act_onehot;
  logic [N_OPS-1:0]    cur_onehot;
  logic [TEXT_W-1:0]   act_text;
  logic [TEXT_W-1:0]   menu_text;

  assign sel_valid  = {1'b0, sel} < N_OPS_L;
  assign cur_onehot = N_OPS'(1) << active_op_q;
  assign act_onehot = N_OPS'(1) << active_op_d;
  assign done_act   = |(op_done & cur_onehot);
  assign menu_text  = sel_valid ? TEXT_W'({MENU_PREFIX, bin2ascii(sel), PAD4, PRESS_LINE})
                                : TEXT_W'({INVALID_LINE, PRESS_LINE});

  always_comb begin
    act_text = TEXT_W'(BLANK_TEXT);
    for (int k = 0; k < N_OPS; k++) begin
      if (active_op_d == 4'(k)) act_text = op_text[k*TEXT_W +: TEXT_W];
    end
  end

`ifdef CALC_TIMEOUT_EN
  calc_op_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .Clk     (Clk),
    .reset   (reset),
    .clear   (state_q != ST_RUN),
    .run     (state_q == ST_RUN),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    active_op_d = active_op_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_next && sel_valid) begin
          active_op_d = sel;
          state_d     = ST_RELEASE;
        end
      end
      ST_RELEASE: state_d = btn_back ? ST_IDLE : ST_ARM;
      ST_ARM:     state_d = btn_back ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        // abort outranks completion, completion outranks the watchdog
        if (btn_back)      state_d = ST_IDLE;
        else if (done_act) state_d = ST_HOLD;
        else if (expired)  state_d = ST_FAULT;
      end
      ST_HOLD:  if (btn_back || btn_next) state_d = ST_IDLE;
      ST_FAULT: if (btn_next) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so the registers line up with the state
  always_comb begin
    op_reset_d  = '1;
    op_enable_d = '0;
    op_next_d   = '0;
    text_d      = menu_text;
    busy_d      = (state_d != ST_IDLE);
    case (state_d)
      ST_RELEASE, ST_HOLD: begin
        op_reset_d  = ~act_onehot;
        op_enable_d = act_onehot;
        text_d      = act_text;
      end
      ST_ARM: begin
        op_reset_d  = ~act_onehot;
        op_enable_d = act_onehot;
        op_next_d   = act_onehot;
        text_d      = act_text;
      end
      ST_RUN: begin
        op_reset_d  = ~act_onehot;
        op_enable_d = act_onehot;
        if ((state_q == ST_RUN) && btn_next) op_next_d = act_onehot;
        text_d      = act_text;
      end
      ST_FAULT: text_d = TEXT_W'(FAULT_TEXT);
      default:  text_d = menu_text;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      active_op_q <= '0;
      op_reset_q  <= '1;
      op_enable_q <= '0;
      op_next_q   <= '0;
      text_q      <= TEXT_W'(BLANK_TEXT);
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_op_q <= active_op_d;
      op_reset_q  <= op_reset_d;
      op_enable_q <= op_enable_d;
      op_next_q   <= op_next_d;
      text_q      <= text_d;
      busy_q      <= busy_d;
    end
  end

`ifdef CALC_TIMEOUT_EN
  logic fault_q, fault_d;

  always_comb fault_d = (state_d == ST_FAULT);

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign op_reset  = op_reset_q;
  assign op_enable = op_enable_q;
  assign op_next   = op_next_q;
  assign textOut   = text_q;
  assign busy      = busy_q;
  assign active_op = active_op_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// tb/tb_calc_op_sequencer.sv - scoreboard bench for calc_op_sequencer
// Honours CALC_TIMEOUT_EN in its reference model (watchdog limit 16).
module tb_calc_op_sequencer;

  localparam int N_OPS  = 4;
  localparam int TEXT_W = 256;
  localparam int TO     = 16;
`ifdef CALC_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam int M_IDLE = 0, M_REL = 1, M_ARM = 2, M_RUN = 3, M_HOLD = 4, M_FAULT = 5;

  logic                    Clk = 1'b0;
  logic                    reset;
  logic [3:0]              sel;
  logic                    btn_next;
  logic                    btn_back;
  logic [N_OPS-1:0]        op_done;
  logic [N_OPS*TEXT_W-1:0] op_text;
  logic [N_OPS-1:0]        op_reset;
  logic [N_OPS-1:0]        op_enable;
  logic [N_OPS-1:0]        op_next;
  logic [TEXT_W-1:0]       textOut;
  logic                    busy;
  logic [3:0]              active_op;
  logic                    fault;

  calc_op_sequencer #(.N_OPS(N_OPS), .TEXT_W(TEXT_W), .TIMEOUT_CYC(TO)) dut (
    .Clk       (Clk),
    .reset     (reset),
    .sel       (sel),
    .btn_next  (btn_next),
    .btn_back  (btn_back),
    .op_done   (op_done),
    .op_text   (op_text),
    .op_reset  (op_reset),
    .op_enable (op_enable),
    .op_next   (op_next),
    .textOut   (textOut),
    .busy      (busy),
    .active_op (active_op),
    .fault     (fault)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [N_OPS-1:0]  rst;
    logic [N_OPS-1:0]  en;
    logic [N_OPS-1:0]  nxt;
    logic [TEXT_W-1:0] txt;
    logic              chk_txt;
    logic              busy;
    logic [3:0]        act;
    logic              flt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int         m_mode;
  int         m_cnt;
  logic [3:0] m_act;

  function automatic logic [TEXT_W-1:0] str2text(input string s);
    logic [TEXT_W-1:0] t;
    t = {32{8'h20}};
    for (int i = 0; i < s.len() && i < 32; i++) t[TEXT_W-1-8*i -: 8] = s[i];
    return t;
  endfunction

  function automatic logic [TEXT_W-1:0] menu_text(input logic [3:0] s);
    string hx;
    string l1;
    hx = "0123456789ABCDEF";
    if (int'(s) < N_OPS) l1 = {"Select Op: ", hx.substr(int'(s), int'(s)), "    "};
    else                 l1 = "Invalid Op      ";
    return str2text({l1, "Press Btnc"});
  endfunction

  task automatic chk(input string name, input logic [TEXT_W-1:0] got, input logic [TEXT_W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %h required %h", name, $time, got, want);
    end
  endtask

  // Behavioural reference: what the user-visible outputs must be after this cycle's inputs
  task automatic model_step(input logic [3:0] s, input logic bn, input logic bb,
                            input logic [N_OPS-1:0] dn, input logic [N_OPS*TEXT_W-1:0] tx,
                            output exp_t e);
    logic fwd;
    fwd = 1'b0;
    case (m_mode)
      M_IDLE:  if (bn && int'(s) < N_OPS) begin m_act = s; m_mode = M_REL; end
      M_REL:   m_mode = bb ? M_IDLE : M_ARM;
      M_ARM:   begin m_mode = bb ? M_IDLE : M_RUN; m_cnt = 0; end
      M_RUN: begin
        if (bb)                                 m_mode = M_IDLE;
        else if (dn[m_act])                     m_mode = M_HOLD;
        else if (TIMEOUT_EN && m_cnt == TO - 1) m_mode = M_FAULT;
        else begin m_cnt++; fwd = bn; end
      end
      M_HOLD:  if (bb || bn) m_mode = M_IDLE;
      M_FAULT: if (bn) m_mode = M_IDLE;
      default: m_mode = M_IDLE;
    endcase
    e.rst     = '1;
    e.en      = '0;
    e.nxt     = '0;
    e.busy    = (m_mode != M_IDLE);
    e.act     = m_act;
    e.flt     = (m_mode == M_FAULT);
    e.chk_txt = 1'b1;
    case (m_mode)
      M_IDLE:  e.txt = menu_text(s);
      M_FAULT: e.txt = str2text("Op Timeout      Press Btnc");
      default: begin
        e.rst[m_act] = 1'b0;
        e.en[m_act]  = 1'b1;
        e.nxt[m_act] = (m_mode == M_ARM) || fwd;
        e.txt        = tx[int'(m_act)*TEXT_W +: TEXT_W];
        e.chk_txt    = (m_mode == M_RUN) || (m_mode == M_HOLD);
      end
    endcase
  endtask

  task automatic cycle(input logic [3:0] s, input logic bn, input logic bb, input logic [N_OPS-1:0] dn);
    exp_t e;
    sel      = s;
    btn_next = bn;
    btn_back = bb;
    op_done  = dn;
    model_step(s, bn, bb, dn, op_text, e);
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    sb_q.delete();
    reset    = 1'b1;
    sel      = '0;
    btn_next = 1'b0;
    btn_back = 1'b0;
    op_done  = '0;
    repeat (3) @(posedge Clk);
    #1;
    reset  = 1'b0;
    m_mode = M_IDLE;
    m_act  = '0;
    m_cnt  = 0;
    e.rst = '1; e.en = '0; e.nxt = '0; e.txt = {32{8'h20}};
    e.chk_txt = 1'b1; e.busy = 1'b0; e.act = '0; e.flt = 1'b0;
    sb_q.push_back(e);
  endtask

  always @(negedge Clk) begin : monitor
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("op_reset", TEXT_W'(op_reset), TEXT_W'(e.rst));
      chk("op_enable", TEXT_W'(op_enable), TEXT_W'(e.en));
      chk("op_next", TEXT_W'(op_next), TEXT_W'(e.nxt));
      chk("busy", TEXT_W'(busy), TEXT_W'(e.busy));
      chk("active_op", TEXT_W'(active_op), TEXT_W'(e.act));
      chk("fault", TEXT_W'(fault), TEXT_W'(e.flt));
      if (e.chk_txt) chk("textOut", textOut, e.txt);
    end
  end

  initial begin
    for (int k = 0; k < N_OPS; k++) op_text[k*TEXT_W +: TEXT_W] = str2text($sformatf("Unit %0d ready", k));
    do_reset();

    // launch unit 0, forward one press, ignore a foreign done, then finish and return
    repeat (2) cycle(4'd0, 1'b0, 1'b0, '0);
    cycle(4'd0, 1'b1, 1'b0, '0);
    repeat (4) cycle(4'd0, 1'b0, 1'b0, '0);
    cycle(4'd0, 1'b1, 1'b0, '0);
    cycle(4'd0, 1'b0, 1'b0, 4'b0010);
    cycle(4'd0, 1'b0, 1'b0, 4'b0001);
    repeat (2) cycle(4'd0, 1'b0, 1'b0, '0);
    cycle(4'd0, 1'b1, 1'b0, '0);
    cycle(4'd0, 1'b0, 1'b0, '0);

    // unit 1 with its own text through HOLD and back
    op_text[1*TEXT_W +: TEXT_W] = str2text("Calculating...");
    cycle(4'd1, 1'b1, 1'b0, '0);
    repeat (5) cycle(4'd1, 1'b0, 1'b0, '0);
    cycle(4'd1, 1'b0, 1'b0, 4'b0010);
    repeat (2) cycle(4'd1, 1'b0, 1'b0, '0);
    cycle(4'd1, 1'b1, 1'b0, '0);
    cycle(4'd1, 1'b0, 1'b0, '0);

    // out-of-range selection is displayed as invalid and ignored
    cycle(4'd5, 1'b0, 1'b0, '0);
    cycle(4'd5, 1'b1, 1'b0, '0);
    repeat (2) cycle(4'd15, 1'b0, 1'b0, '0);
    cycle(4'd10, 1'b1, 1'b0, '0);

    // back and next together in RUN; back and done together in RUN
    cycle(4'd2, 1'b1, 1'b0, '0);
    repeat (4) cycle(4'd2, 1'b0, 1'b0, '0);
    cycle(4'd2, 1'b1, 1'b1, '0);
    repeat (2) cycle(4'd2, 1'b0, 1'b0, '0);
    cycle(4'd3, 1'b1, 1'b0, '0);
    repeat (3) cycle(4'd3, 1'b0, 1'b0, '0);
    cycle(4'd3, 1'b0, 1'b1, 4'b1000);
    cycle(4'd3, 1'b0, 1'b0, '0);

    // long RUN with no done, then done on the last allowed RUN cycle
    cycle(4'd3, 1'b1, 1'b0, '0);
    repeat (22) cycle(4'd3, 1'b0, 1'b0, '0);
    cycle(4'd3, 1'b1, 1'b0, '0);
    cycle(4'd3, 1'b0, 1'b0, '0);
    cycle(4'd3, 1'b1, 1'b0, '0);
    repeat (2) cycle(4'd3, 1'b0, 1'b0, '0);
    repeat (TO - 1) cycle(4'd3, 1'b0, 1'b0, '0);
    cycle(4'd3, 1'b0, 1'b0, 4'b1000);
    repeat (2) cycle(4'd3, 1'b0, 1'b0, '0);
    cycle(4'd3, 1'b1, 1'b0, '0);

    // asynchronous reset in the middle of RUN
    cycle(4'd2, 1'b1, 1'b0, '0);
    repeat (5) cycle(4'd2, 1'b0, 1'b0, '0);
    sb_q.delete();
    reset = 1'b1;
    #1;
    chk("async_op_reset", TEXT_W'(op_reset), TEXT_W'({N_OPS{1'b1}}));
    chk("async_op_enable", TEXT_W'(op_enable), '0);
    chk("async_textOut", textOut, {32{8'h20}});
    chk("async_active_op", TEXT_W'(active_op), '0);
    chk("async_busy", TEXT_W'(busy), '0);
    do_reset();

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic [3:0]       s;
      logic             bn, bb;
      logic [N_OPS-1:0] dn;
      s  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      bn = ($urandom_range(0, 3) == 0);
      bb = ($urandom_range(0, 24) == 0);
      dn = ($urandom_range(0, 11) == 0) ? N_OPS'($urandom) : '0;
      if ($urandom_range(0, 15) == 0) begin
        int k;
        k = $urandom_range(0, N_OPS - 1);
        for (int j = 0; j < TEXT_W / 32; j++) op_text[k*TEXT_W + 32*j +: 32] = $urandom;
      end
      cycle(s, bn, bb, dn);
    end

    @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
